// File: rtl/sd_dma_pkg.sv
// Shared types and constants for the SD multi-sector DMA sequencer:
// FSM states, card MMIO map, config register map and byte-swap helper.
package sd_dma_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PRE_POLL,
      ST_SET_ADDR,
      ST_TRIG,
      ST_GUARD,
      ST_POLL,
      ST_COPY_OUT,
      ST_COPY_IN,
      ST_NEXT
   } state_e;

   localparam logic [15:0] CARD_ADDR    = 16'h1000;
   localparam logic [15:0] CARD_RD_TRIG = 16'h1004;
   localparam logic [15:0] CARD_WR_TRIG = 16'h1008;
   localparam logic [15:0] CARD_STATUS  = 16'h2010;

   localparam logic [31:0] CARD_CMD_GO = 32'h0100_0000;
   localparam int unsigned READY_BIT   = 24;

   localparam logic [4:0] CFG_CTRL    = 5'h00;
   localparam logic [4:0] CFG_SECTOR  = 5'h04;
   localparam logic [4:0] CFG_MEMBASE = 5'h08;
   localparam logic [4:0] CFG_COUNT   = 5'h0C;
   localparam logic [4:0] CFG_STATUS  = 5'h10;

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/sd_dma_sequencer_if.sv
// System memory port of the sequencer: one outstanding read or write,
// request held until the single-cycle mem_ready completion.
interface sd_dma_sequencer_if;
   logic [31:0] mem_a;
   logic [31:0] mem_d;
   logic        mem_we;
   logic        mem_rd;
   logic [31:0] mem_spo;
   logic        mem_ready;

   modport master (
      output mem_a, mem_d, mem_we, mem_rd,
      input  mem_spo, mem_ready
   );

   modport slave (
      input  mem_a, mem_d, mem_we, mem_rd,
      output mem_spo, mem_ready
   );
endinterface

// File: rtl/sd_dma_regs.sv
// Config register file: CTRL/SECTOR/MEMBASE/COUNT/STATUS, start pulse
// generation, done/err sticky flags and the level interrupt.
module sd_dma_regs
   import sd_dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  cfg_a,
   input  logic [31:0] cfg_d,
   input  logic        cfg_we,
   output logic [31:0] cfg_spo,
   input  logic        busy,
   input  logic [15:0] remaining,
   input  logic        sector_inc,
   input  logic        set_done,
   input  logic        set_err,
   output logic        go,
   output logic        dir,
   output logic [31:0] sector,
   output logic [31:0] membase,
   output logic [15:0] count,
   output logic        irq
);

   logic        dir_q, dir_d;
   logic        irq_en_q, irq_en_d;
   logic [31:0] sector_q, sector_d;
   logic [31:0] membase_q, membase_d;
   logic [15:0] count_q, count_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        wr_ok;
   logic        start;

   always_comb begin
      dir_d     = dir_q;
      irq_en_d  = irq_en_q;
      sector_d  = sector_q;
      membase_d = membase_q;
      count_d   = count_q;
      done_d    = done_q;
      err_d     = err_q;
      wr_ok     = cfg_we & ~busy;
      start     = wr_ok & (cfg_a == CFG_CTRL) & cfg_d[0];
      go        = start & (count_q != '0);

      if (wr_ok) begin
         case (cfg_a)
            CFG_CTRL: begin
               dir_d    = cfg_d[1];
               irq_en_d = cfg_d[2];
            end
            CFG_SECTOR:  sector_d  = cfg_d;
            CFG_MEMBASE: membase_d = {cfg_d[31:2], 2'b00};
            CFG_COUNT:   count_d   = cfg_d[15:0];
            default: ;
         endcase
      end
      if (sector_inc)
         sector_d = sector_q + 32'd1;

      if (cfg_we && cfg_a == CFG_STATUS) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
      // A zero-sector start completes instantly as an error without touching the card
      if (start) begin
         done_d = (count_q == '0);
         err_d  = (count_q == '0);
      end
      if (set_done) done_d = 1'b1;
      if (set_err)  err_d  = 1'b1;
   end

   always_comb begin
      case (cfg_a)
         CFG_CTRL:    cfg_spo = {29'b0, irq_en_q, dir_q, 1'b0};
         CFG_SECTOR:  cfg_spo = sector_q;
         CFG_MEMBASE: cfg_spo = membase_q;
         CFG_COUNT:   cfg_spo = {16'b0, count_q};
         CFG_STATUS:  cfg_spo = {remaining, 13'b0, err_q, done_q, busy};
         default:     cfg_spo = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q     <= 1'b0;
         irq_en_q  <= 1'b0;
         sector_q  <= '0;
         membase_q <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         irq_en_q  <= irq_en_d;
         sector_q  <= sector_d;
         membase_q <= membase_d;
         count_q   <= count_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign dir     = dir_q;
   assign sector  = sector_q;
   assign membase = membase_q;
   assign count   = count_q;
   assign irq     = irq_en_q & (done_q | err_q);

endmodule

// File: rtl/sd_dma_sequencer.sv
// Multi-sector DMA between the SPI-mode SD card block and system memory;
// owns the card port and passes CPU accesses through while idle.
module sd_dma_sequencer
   import sd_dma_pkg::*;
#(
   parameter int unsigned ADDR_SHIFT     = 9,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'hffffff
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         cfg_a,
   input  logic [31:0]        cfg_d,
   input  logic               cfg_we,
   output logic [31:0]        cfg_spo,
   input  logic [15:0]        cpu_sd_a,
   input  logic [31:0]        cpu_sd_d,
   input  logic               cpu_sd_we,
   output logic [31:0]        cpu_sd_spo,
   output logic [15:0]        sd_a,
   output logic [31:0]        sd_d,
   output logic               sd_we,
   input  logic [31:0]        sd_spo,
   sd_dma_sequencer_if.master mem,
   output logic               irq
);

   state_e      state_q, state_d;
   logic [6:0]  idx_q, idx_d;
   logic        phase_q, phase_d;
   logic [31:0] data_q, data_d;
   logic [31:0] cur_mem_q, cur_mem_d;
   logic [15:0] rem_q, rem_d;
   logic [23:0] tmo_q, tmo_d;

   logic        busy, go, dir, sector_inc, set_done, set_err;
   logic [31:0] sector, membase;
   logic [15:0] count;
   logic        ready, tmo_hit;
   logic [31:0] card_addr, word_mem_a;
   logic [15:0] word_sd_a;

   assign busy       = (state_q != ST_IDLE);
   assign ready      = sd_spo[READY_BIT];
   assign tmo_hit    = (tmo_q == TIMEOUT_CYCLES - 24'd1);
   assign card_addr  = bswap32(sector << ADDR_SHIFT);
   assign word_mem_a = cur_mem_q + {23'b0, idx_q, 2'b00};
   assign word_sd_a  = {7'b0, idx_q, 2'b00};

   sd_dma_regs u_regs (
      .clk        (clk),
      .rst        (rst),
      .cfg_a      (cfg_a),
      .cfg_d      (cfg_d),
      .cfg_we     (cfg_we),
      .cfg_spo    (cfg_spo),
      .busy       (busy),
      .remaining  (rem_q),
      .sector_inc (sector_inc),
      .set_done   (set_done),
      .set_err    (set_err),
      .go         (go),
      .dir        (dir),
      .sector     (sector),
      .membase    (membase),
      .count      (count),
      .irq        (irq)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      phase_d    = phase_q;
      data_d     = data_q;
      cur_mem_d  = cur_mem_q;
      rem_d      = rem_q;
      tmo_d      = tmo_q;
      sector_inc = 1'b0;
      set_done   = 1'b0;
      set_err    = 1'b0;
      sd_a       = '0;
      sd_d       = '0;
      sd_we      = 1'b0;
      cpu_sd_spo = '0;
      mem.mem_a  = '0;
      mem.mem_d  = '0;
      mem.mem_we = 1'b0;
      mem.mem_rd = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rst) begin
               sd_a       = cpu_sd_a;
               sd_d       = cpu_sd_d;
               sd_we      = cpu_sd_we;
               cpu_sd_spo = sd_spo;
            end
            if (go) begin
               state_d   = ST_PRE_POLL;
               cur_mem_d = membase;
               rem_d     = count;
               tmo_d     = '0;
            end
         end
         ST_PRE_POLL, ST_POLL: begin
            sd_a = CARD_STATUS;
            if (ready) begin
               idx_d   = '0;
               phase_d = 1'b0;
               if (state_q == ST_PRE_POLL) state_d = dir ? ST_COPY_IN : ST_SET_ADDR;
               else                        state_d = dir ? ST_NEXT : ST_COPY_OUT;
            end else if (tmo_hit) begin
               state_d  = ST_IDLE;
               set_err  = 1'b1;
               set_done = 1'b1;
            end else begin
               tmo_d = tmo_q + 24'd1;
            end
         end
         ST_SET_ADDR: begin
            sd_a    = CARD_ADDR;
            sd_d    = card_addr;
            sd_we   = 1'b1;
            state_d = ST_TRIG;
         end
         ST_TRIG: begin
            sd_a    = dir ? CARD_WR_TRIG : CARD_RD_TRIG;
            sd_d    = CARD_CMD_GO;
            sd_we   = 1'b1;
            tmo_d   = '0;
            state_d = ST_GUARD;
         end
         // tmo_q doubles as the two-cycle guard counter before polling starts
         ST_GUARD: begin
            sd_a = CARD_STATUS;
            if (tmo_q == 24'd1) begin
               tmo_d   = '0;
               state_d = ST_POLL;
            end else begin
               tmo_d = tmo_q + 24'd1;
            end
         end
         ST_COPY_OUT: begin
            if (!phase_q) begin
               sd_a    = word_sd_a;
               data_d  = sd_spo;
               phase_d = 1'b1;
            end else begin
               mem.mem_we = 1'b1;
               mem.mem_a  = word_mem_a;
               mem.mem_d  = data_q;
               if (mem.mem_ready) begin
                  phase_d = 1'b0;
                  idx_d   = idx_q + 7'd1;
                  if (idx_q == 7'd127) state_d = ST_NEXT;
               end
            end
         end
         ST_COPY_IN: begin
            if (!phase_q) begin
               mem.mem_rd = 1'b1;
               mem.mem_a  = word_mem_a;
               if (mem.mem_ready) begin
                  data_d  = mem.mem_spo;
                  phase_d = 1'b1;
               end
            end else begin
               sd_a    = word_sd_a;
               sd_d    = data_q;
               sd_we   = 1'b1;
               phase_d = 1'b0;
               idx_d   = idx_q + 7'd1;
               if (idx_q == 7'd127) state_d = ST_SET_ADDR;
            end
         end
         ST_NEXT: begin
            sector_inc = 1'b1;
            cur_mem_d  = cur_mem_q + 32'd512;
            rem_d      = rem_q - 16'd1;
            tmo_d      = '0;
            if (rem_q == 16'd1) begin
               state_d  = ST_IDLE;
               set_done = 1'b1;
            end else begin
               state_d = ST_PRE_POLL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         phase_q   <= 1'b0;
         data_q    <= '0;
         cur_mem_q <= '0;
         rem_q     <= '0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         phase_q   <= phase_d;
         data_q    <= data_d;
         cur_mem_q <= cur_mem_d;
         rem_q     <= rem_d;
         tmo_q     <= tmo_d;
      end
   end

endmodule

// File: tb/tb_sd_dma_sequencer.sv
// Directed bench: two sequencer instances (ADDR_SHIFT 9 and 0) share one
// card model and one memory model through a select mux.
module tb_sd_dma_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic [4:0]  cfg_a;
   logic [31:0] cfg_d;
   logic        cfg_we;
   logic [15:0] cpu_sd_a;
   logic [31:0] cpu_sd_d;
   logic        cpu_sd_we;

   logic [31:0] cfg_spo0, cfg_spo1, cfg_spo;
   logic [31:0] cpu_sd_spo0, cpu_sd_spo1, cpu_sd_spo;
   logic [15:0] sd_a0, sd_a1, sd_a;
   logic [31:0] sd_d0, sd_d1, sd_d;
   logic        sd_we0, sd_we1, sd_we;
   logic [31:0] sd_spo;
   logic        irq0, irq1, irq;
   logic        cfg_we0, cfg_we1;
   logic [31:0] mem_a, mem_d, mem_spo;
   logic        mem_we, mem_rd, mem_ready;

   int unsigned errors = 0;
   int unsigned checks = 0;

   sd_dma_sequencer_if m0 ();
   sd_dma_sequencer_if m1 ();

   always #5 clk = ~clk;

   assign cfg_we0 = cfg_we & ~sel;
   assign cfg_we1 = cfg_we & sel;

   sd_dma_sequencer #(.ADDR_SHIFT(9), .TIMEOUT_CYCLES(24'd100)) u0 (
      .clk(clk), .rst(rst), .cfg_a(cfg_a), .cfg_d(cfg_d), .cfg_we(cfg_we0), .cfg_spo(cfg_spo0),
      .cpu_sd_a(cpu_sd_a), .cpu_sd_d(cpu_sd_d), .cpu_sd_we(cpu_sd_we), .cpu_sd_spo(cpu_sd_spo0),
      .sd_a(sd_a0), .sd_d(sd_d0), .sd_we(sd_we0), .sd_spo(sd_spo), .mem(m0), .irq(irq0)
   );

   sd_dma_sequencer #(.ADDR_SHIFT(0), .TIMEOUT_CYCLES(24'd100)) u1 (
      .clk(clk), .rst(rst), .cfg_a(cfg_a), .cfg_d(cfg_d), .cfg_we(cfg_we1), .cfg_spo(cfg_spo1),
      .cpu_sd_a(cpu_sd_a), .cpu_sd_d(cpu_sd_d), .cpu_sd_we(cpu_sd_we), .cpu_sd_spo(cpu_sd_spo1),
      .sd_a(sd_a1), .sd_d(sd_d1), .sd_we(sd_we1), .sd_spo(sd_spo), .mem(m1), .irq(irq1)
   );

   assign cfg_spo    = sel ? cfg_spo1 : cfg_spo0;
   assign cpu_sd_spo = sel ? cpu_sd_spo1 : cpu_sd_spo0;
   assign sd_a       = sel ? sd_a1 : sd_a0;
   assign sd_d       = sel ? sd_d1 : sd_d0;
   assign sd_we      = sel ? sd_we1 : sd_we0;
   assign irq        = sel ? irq1 : irq0;
   assign mem_a      = sel ? m1.mem_a : m0.mem_a;
   assign mem_d      = sel ? m1.mem_d : m0.mem_d;
   assign mem_we     = sel ? m1.mem_we : m0.mem_we;
   assign mem_rd     = sel ? m1.mem_rd : m0.mem_rd;
   assign m0.mem_spo   = mem_spo;
   assign m1.mem_spo   = mem_spo;
   assign m0.mem_ready = mem_ready & ~sel;
   assign m1.mem_ready = mem_ready & sel;

   // Card model: 128-word cache, busy for a few cycles after a trigger
   logic [31:0] cache [128];
   logic [47:0] sdlog [$];
   int unsigned busy_cnt = 0;
   logic        trig_seen = 1'b0;
   logic        hang_mode = 1'b0;
   logic        card_init = 1'b0;
   logic        card_rdy;

   assign card_rdy = (busy_cnt == 0) && !(hang_mode && trig_seen);
   assign sd_spo = (sd_a == 16'h2010) ? (card_rdy ? 32'h0100_0000 : 32'h0) :
                   (sd_a[15:9] == 7'd0) ? cache[sd_a[8:2]] : 32'h0;

   always @(posedge clk) begin
      if (card_init) begin
         for (int i = 0; i < 128; i++) cache[i] <= 32'hA000_0000 + 32'(i);
         trig_seen <= 1'b0;
         busy_cnt  <= 0;
      end else if (sd_we) begin
         sdlog.push_back({sd_a, sd_d});
         if (sd_a == 16'h1004 || sd_a == 16'h1008) begin
            busy_cnt  <= 3;
            trig_seen <= 1'b1;
         end else if (sd_a[15:9] == 7'd0) begin
            cache[sd_a[8:2]] <= sd_d;
         end
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   // Memory model: completion pulse two cycles into each request
   logic [63:0] mwlog [$];
   logic [31:0] mrlog [$];
   int unsigned lat = 0;
   logic        both_seen = 1'b0;

   assign mem_spo = 32'hB000_0000 ^ mem_a;

   always @(posedge clk) begin
      mem_ready <= 1'b0;
      if ((mem_we || mem_rd) && !mem_ready) begin
         if (lat == 1) begin
            mem_ready <= 1'b1;
            lat <= 0;
         end else begin
            lat <= lat + 1;
         end
      end else begin
         lat <= 0;
      end
      if (mem_ready && mem_we) mwlog.push_back({mem_a, mem_d});
      if (mem_ready && mem_rd) mrlog.push_back(mem_a);
      if (mem_we && mem_rd) both_seen <= 1'b1;
   end

   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      cfg_a = a; cfg_d = d; cfg_we = 1'b1;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
      @(posedge clk); #2;
      cfg_a = a;
      #1 d = cfg_spo;
   endtask

   task automatic wait_idle(input int unsigned budget, output bit ok);
      logic [31:0] s;
      int unsigned n = 0;
      do begin
         cfg_read(5'h10, s);
         n++;
      end while (s[0] && n < budget);
      ok = !s[0];
   endtask

   task automatic card_reset();
      @(posedge clk); #1 card_init = 1'b1;
      @(posedge clk); #1 card_init = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      #3;
      checks++; if (sd_we !== 1'b0 || sd_a !== 16'h0 || sd_d !== 32'h0) begin errors++;
         $display("FAIL reset_sd: sd_we=%b sd_a=%h sd_d=%h expected 0", sd_we, sd_a, sd_d); end
      checks++; if (m0.mem_we !== 1'b0 || m0.mem_rd !== 1'b0 || m0.mem_a !== 32'h0 || m0.mem_d !== 32'h0) begin errors++;
         $display("FAIL reset_mem: we=%b rd=%b a=%h d=%h expected 0", m0.mem_we, m0.mem_rd, m0.mem_a, m0.mem_d); end
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq0); end
      cfg_a = 5'h10; #1;
      checks++; if (cfg_spo !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", cfg_spo); end
      @(posedge clk); #1 rst = 1'b0;
      cpu_sd_a = 16'h0;
      cfg_read(5'h04, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_sector: got %h expected 0", v); end
   endtask

   task automatic test_read_sector();
      logic [31:0] v;
      bit ok;
      int unsigned s0, w0, nw;
      sel = 1'b0;
      card_reset();
      s0 = sdlog.size(); w0 = mwlog.size();
      cfg_write(5'h04, 32'd5);
      cfg_write(5'h08, 32'h0000_1003);
      cfg_write(5'h0C, 32'd1);
      cfg_write(5'h00, 32'h5);
      wait_idle(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL read_timeout: busy after 3000 cycles, expected idle"); end
      checks++; if (sdlog.size() - s0 !== 2) begin errors++; $display("FAIL read_sd_count: got %0d writes expected 2", sdlog.size() - s0); end
      if (sdlog.size() - s0 >= 2) begin
         checks++; if (sdlog[s0] !== {16'h1000, 32'h000A_0000}) begin errors++;
            $display("FAIL read_addr_write: got %h expected 1000000a0000", sdlog[s0]); end
         checks++; if (sdlog[s0+1] !== {16'h1004, 32'h0100_0000}) begin errors++;
            $display("FAIL read_trig: got %h expected 100401000000", sdlog[s0+1]); end
      end
      nw = mwlog.size() - w0;
      checks++; if (nw !== 128) begin errors++; $display("FAIL read_mem_count: got %0d expected 128", nw); end
      for (int i = 0; i < 128 && i < int'(nw); i++) begin
         checks++;
         if (mwlog[w0+i] !== {32'h1000 + 32'(i*4), 32'hA000_0000 + 32'(i)}) begin errors++;
            $display("FAIL read_mem_word%0d: got %h expected addr %h data %h", i, mwlog[w0+i], 32'h1000 + 32'(i*4), 32'hA000_0000 + 32'(i)); end
      end
      cfg_read(5'h10, v);
      checks++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL read_status: got %h expected 00000002", v); end
      checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL read_irq: got %b expected 1", irq0); end
      cfg_read(5'h04, v);
      checks++; if (v !== 32'd6) begin errors++; $display("FAIL read_sector_inc: got %h expected 6", v); end
      cfg_write(5'h10, 32'h0);
      #1;
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL read_irq_clear: got %b expected 0", irq0); end
   endtask

   task automatic test_write_multi();
      logic [31:0] exp_addr [3];
      logic [47:0] e;
      logic [31:0] v;
      bit ok;
      int unsigned s0, r0, nr, na, nt, nc;
      exp_addr = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0100_0000};
      sel = 1'b1;
      card_reset();
      s0 = sdlog.size(); r0 = mrlog.size();
      cfg_write(5'h04, 32'hFFFF_FFFF);
      cfg_write(5'h08, 32'h0000_2000);
      cfg_write(5'h0C, 32'd3);
      cfg_write(5'h00, 32'h3);
      wait_idle(6000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL write_timeout: busy after 6000 cycles, expected idle"); end
      nr = mrlog.size() - r0;
      checks++; if (nr !== 384) begin errors++; $display("FAIL write_mem_count: got %0d expected 384", nr); end
      for (int j = 0; j < 384 && j < int'(nr); j++) begin
         checks++;
         if (mrlog[r0+j] !== 32'h2000 + 32'(j*4)) begin errors++;
            $display("FAIL write_mem_rd%0d: got %h expected %h", j, mrlog[r0+j], 32'h2000 + 32'(j*4)); end
      end
      na = 0; nt = 0; nc = 0;
      for (int k = int'(s0); k < sdlog.size(); k++) begin
         e = sdlog[k];
         if (e[47:32] == 16'h1000) begin
            if (na < 3) begin
               checks++; if (e[31:0] !== exp_addr[na]) begin errors++;
                  $display("FAIL write_card_addr%0d: got %h expected %h", na, e[31:0], exp_addr[na]); end
            end
            na++;
         end else if (e[47:32] == 16'h1008) begin
            checks++; if (e[31:0] !== 32'h0100_0000) begin errors++;
               $display("FAIL write_trig_data: got %h expected 01000000", e[31:0]); end
            nt++;
         end else begin
            checks++;
            if (e !== {16'((nc % 128) * 4), 32'hB000_0000 ^ (32'h2000 + 32'(nc*4))}) begin errors++;
               $display("FAIL write_cache%0d: got %h expected a=%h d=%h", nc, e, 16'((nc % 128) * 4), 32'hB000_0000 ^ (32'h2000 + 32'(nc*4))); end
            nc++;
         end
      end
      checks++; if (na !== 3 || nt !== 3 || nc !== 384) begin errors++;
         $display("FAIL write_sd_counts: got addr=%0d trig=%0d cache=%0d expected 3 3 384", na, nt, nc); end
      cfg_read(5'h04, v);
      checks++; if (v !== 32'd2) begin errors++; $display("FAIL write_sector_wrap: got %h expected 2", v); end
      cfg_read(5'h10, v);
      checks++; if (v !== 32'h2 || irq1 !== 1'b0) begin errors++;
         $display("FAIL write_status: got %h irq=%b expected 00000002 irq=0", v, irq1); end
      cfg_write(5'h10, 32'h0);
      sel = 1'b0;
   endtask

   task automatic test_timeout();
      logic [31:0] v;
      int unsigned n, s1;
      bit seen;
      sel = 1'b0;
      hang_mode = 1'b1;
      card_reset();
      cfg_write(5'h04, 32'h0);
      cfg_write(5'h0C, 32'd1);
      cfg_write(5'h00, 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk); #1;
         if (sd_we && sd_a == 16'h1004) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL tmo_trig: no read trigger within 50 cycles, expected one"); end
      cfg_a = 5'h10;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!cfg_spo[2] && n < 300);
      checks++; if (n < 100 || n > 105) begin errors++;
         $display("FAIL tmo_latency: err after %0d cycles from trigger, expected 100..105", n); end
      checks++; if (cfg_spo[2:0] !== 3'b110) begin errors++;
         $display("FAIL tmo_status: got %b expected 110", cfg_spo[2:0]); end
      s1 = sdlog.size();
      repeat (20) @(posedge clk);
      #1;
      checks++; if (sdlog.size() !== s1) begin errors++;
         $display("FAIL tmo_quiet: got %0d sd writes after timeout expected 0", sdlog.size() - s1); end
      hang_mode = 1'b0;
      cfg_write(5'h10, 32'h0);
      cfg_read(5'h10, v);
      checks++; if (v[2:0] !== 3'b000) begin errors++; $display("FAIL tmo_clear: got %b expected 000", v[2:0]); end
   endtask

   task automatic test_passthrough();
      bit ok, leak, spo_bad, seen;
      sel = 1'b0;
      card_reset();
      @(posedge clk); #1;
      cpu_sd_a = 16'h1000; cpu_sd_d = 32'h0000_0055; cpu_sd_we = 1'b1;
      #1;
      checks++; if (sd_we !== 1'b1 || sd_a !== 16'h1000 || sd_d !== 32'h55) begin errors++;
         $display("FAIL pass_idle_wr: got we=%b a=%h d=%h expected 1 1000 00000055", sd_we, sd_a, sd_d); end
      cpu_sd_we = 1'b0; cpu_sd_a = 16'h2010;
      #1;
      checks++; if (cpu_sd_spo !== 32'h0100_0000) begin errors++;
         $display("FAIL pass_idle_rd: got %h expected 01000000", cpu_sd_spo); end
      cpu_sd_a = 16'h0;
      cfg_write(5'h0C, 32'd1);
      cfg_write(5'h00, 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk); #1;
         if (m0.mem_we) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL pass_wait_copy: no mem_we within 300 cycles, expected one"); end
      cpu_sd_a = 16'h0004; cpu_sd_d = 32'hDEAD_BEEF; cpu_sd_we = 1'b1;
      leak = 1'b0; spo_bad = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (sd_we) leak = 1'b1;
         if (cpu_sd_spo !== 32'h0) spo_bad = 1'b1;
      end
      cpu_sd_we = 1'b0;
      checks++; if (leak !== 1'b0) begin errors++; $display("FAIL pass_busy_we: sd_we seen=%b expected 0", leak); end
      checks++; if (spo_bad !== 1'b0) begin errors++; $display("FAIL pass_busy_spo: nonzero seen=%b expected 0", spo_bad); end
      wait_idle(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL pass_done: busy after 3000 cycles, expected idle"); end
      cfg_write(5'h10, 32'h0);
   endtask

   task automatic test_busy_writes();
      logic [31:0] v;
      bit ok;
      int unsigned s0;
      sel = 1'b0;
      card_reset();
      cfg_write(5'h04, 32'h10);
      cfg_write(5'h0C, 32'd1);
      cfg_write(5'h00, 32'h1);
      cfg_write(5'h04, 32'h77);
      cfg_write(5'h0C, 32'd9);
      wait_idle(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy_done: busy after 3000 cycles, expected idle"); end
      cfg_read(5'h04, v);
      checks++; if (v !== 32'h11) begin errors++; $display("FAIL busy_sector: got %h expected 11", v); end
      cfg_read(5'h0C, v);
      checks++; if (v !== 32'h1) begin errors++; $display("FAIL busy_count: got %h expected 1", v); end
      cfg_write(5'h10, 32'h0);
      cfg_write(5'h0C, 32'd0);
      s0 = sdlog.size();
      cfg_write(5'h00, 32'h1);
      cfg_read(5'h10, v);
      checks++; if (v !== 32'h6) begin errors++; $display("FAIL zero_status: got %h expected 00000006", v); end
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL zero_irq_off: got %b expected 0", irq0); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (sdlog.size() !== s0) begin errors++;
         $display("FAIL zero_no_sd: got %0d sd writes expected 0", sdlog.size() - s0); end
      cfg_write(5'h00, 32'h4);
      checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL zero_irq_on: got %b expected 1", irq0); end
      cfg_write(5'h10, 32'h0);
      #1;
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL zero_irq_clear: got %b expected 0", irq0); end
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      bit seen;
      sel = 1'b0;
      card_reset();
      cfg_write(5'h04, 32'h9);
      cfg_write(5'h0C, 32'd1);
      cfg_write(5'h00, 32'h1);
      cfg_a = 5'h10;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk); #1;
         if (m0.mem_we) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL arst_wait: no mem_we within 300 cycles, expected one"); end
      #2 rst = 1'b1;
      #1;
      checks++; if (m0.mem_we !== 1'b0 || m0.mem_a !== 32'h0) begin errors++;
         $display("FAIL arst_mem: got we=%b a=%h expected 0 0", m0.mem_we, m0.mem_a); end
      checks++; if (cfg_spo !== 32'h0) begin errors++; $display("FAIL arst_status: got %h expected 0", cfg_spo); end
      #1 rst = 1'b0;
      cfg_read(5'h04, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL arst_sector: got %h expected 0", v); end
      checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL mem_excl: rd&we together seen=%b expected 0", both_seen); end
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0;
      cfg_a = '0; cfg_d = '0; cfg_we = 1'b0;
      cpu_sd_a = 16'h1234; cpu_sd_d = 32'h5678_9ABC; cpu_sd_we = 1'b1;
      test_reset();
      cpu_sd_we = 1'b0;
      test_read_sector();
      test_write_multi();
      test_timeout();
      test_passthrough();
      test_busy_writes();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
